// File: rtl/dm_result_drain.sv
//==============================================================================
// Module      : dm_result_drain
// Description : Watches CPU data-memory stores for the done marker, then drains
//               the answer region through a granted DM read port onto a
//               valid/ready stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dm_result_drain #(
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] ANSWER_START = 16'h9000,
    parameter int unsigned       NUM_WORDS    = 64,
    parameter logic [ADDR_W-1:0] DONE_ADDR    = 16'hFFFC,
    parameter logic [7:0]        DONE_VALUE   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_gnt_i,
    input  logic [31:0]       rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_data_o,
    output logic [7:0]        out_idx_o,
    output logic              out_last_o,
    output logic              done_seen_o,
    output logic              busy_o,
    output logic              drain_done_o,
    output logic              ovw_err_o,
    output logic [31:0]       cycle_cnt_o
);

    typedef enum logic [1:0] {
        S_WATCH = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [8:0]  C_NUM      = 9'(NUM_WORDS);
    localparam logic [8:0]  C_LAST_IDX = 9'(NUM_WORDS - 1);
    localparam logic [31:0] C_SPAN     = 32'(4 * NUM_WORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_cycle_cnt;
    logic              r_done_seen;
    logic              r_drain_done;
    logic              r_ovw_err;
    logic [8:0]        r_issue_idx;
    logic              r_inflight;
    logic [7:0]        r_inflight_idx;
    logic [31:0]       r_fifo_data [2];
    logic [7:0]        r_fifo_idx  [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_detect;
    logic              w_busy;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_req;
    logic              w_gnt;
    logic [ADDR_W-1:0] w_ovw_off;
    logic              w_ovw_hit;

    assign w_detect = (r_state == S_WATCH) && dm_we_i[0]
                   && (dm_addr_i[ADDR_W-1:2] == DONE_ADDR[ADDR_W-1:2])
                   && (dm_wdata_i[7:0] == DONE_VALUE);

    assign w_busy = (r_state == S_DRAIN) || (r_state == S_FLUSH);
    assign w_pop  = out_valid_o && out_ready_i;
    assign w_push = r_inflight;

    // A pop this cycle frees a slot, so a new read may be issued alongside it
    // and the stream keeps one word per cycle with a single-cycle read latency.
    assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_req = (r_state == S_DRAIN) && (r_issue_idx < C_NUM) && (w_occ < 3'd2);
    assign w_gnt = w_req && rd_gnt_i;

    // Offset relative to the region base handles a region that wraps the address space.
    assign w_ovw_off = {dm_addr_i[ADDR_W-1:2], 2'b00} - ANSWER_START;
    assign w_ovw_hit = w_busy && (|dm_we_i) && (32'(w_ovw_off) < C_SPAN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WATCH: if (w_detect) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_gnt && (r_issue_idx == C_LAST_IDX)) w_state_nxt = S_FLUSH;
            S_FLUSH: if ((r_count == 2'd0) && !r_inflight) w_state_nxt = S_FIN;
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_WATCH;
            r_cycle_cnt    <= '0;
            r_done_seen    <= 1'b0;
            r_drain_done   <= 1'b0;
            r_ovw_err      <= 1'b0;
            r_issue_idx    <= '0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= '0;
            r_wptr         <= 1'b0;
            r_rptr         <= 1'b0;
            r_count        <= '0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_idx[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == S_WATCH) && !w_detect && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (w_detect) r_done_seen <= 1'b1;
            if (w_pop && out_last_o) r_drain_done <= 1'b1;
            if (w_ovw_hit) r_ovw_err <= 1'b1;

            r_inflight <= w_gnt;
            if (w_gnt) begin
                r_inflight_idx <= r_issue_idx[7:0];
                r_issue_idx    <= r_issue_idx + 9'd1;
            end

            if (w_push) begin
                r_fifo_data[r_wptr] <= rd_data_i;
                r_fifo_idx[r_wptr]  <= r_inflight_idx;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign rd_req_o     = w_req;
    assign rd_addr_o    = (r_state == S_DRAIN) ? (ANSWER_START + ADDR_W'({r_issue_idx, 2'b00}))
                                               : '0;
    assign out_valid_o  = (r_count != 2'd0);
    assign out_data_o   = r_fifo_data[r_rptr];
    assign out_idx_o    = r_fifo_idx[r_rptr];
    assign out_last_o   = out_valid_o && (out_idx_o == C_LAST_IDX[7:0]);
    assign done_seen_o  = r_done_seen;
    assign busy_o       = w_busy;
    assign drain_done_o = r_drain_done;
    assign ovw_err_o    = r_ovw_err;
    assign cycle_cnt_o  = r_cycle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dm_result_drain.sv
//==============================================================================
// Module      : tb_dm_result_drain
// Description : Scoreboard bench for dm_result_drain with a 1-cycle DM model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dm_result_drain;

    logic        clk;
    logic        rst;
    logic [3:0]  dm_we_i;
    logic [15:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        rd_req_o;
    logic [15:0] rd_addr_o;
    logic        rd_gnt_i;
    logic [31:0] rd_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [7:0]  out_idx_o;
    logic        out_last_o;
    logic        done_seen_o;
    logic        busy_o;
    logic        drain_done_o;
    logic        ovw_err_o;
    logic [31:0] cycle_cnt_o;

    dm_result_drain dut (
        .clk          (clk),
        .rst          (rst),
        .dm_we_i      (dm_we_i),
        .dm_addr_i    (dm_addr_i),
        .dm_wdata_i   (dm_wdata_i),
        .rd_req_o     (rd_req_o),
        .rd_addr_o    (rd_addr_o),
        .rd_gnt_i     (rd_gnt_i),
        .rd_data_i    (rd_data_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_idx_o    (out_idx_o),
        .out_last_o   (out_last_o),
        .done_seen_o  (done_seen_o),
        .busy_o       (busy_o),
        .drain_done_o (drain_done_o),
        .ovw_err_o    (ovw_err_o),
        .cycle_cnt_o  (cycle_cnt_o)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [39:0] exp_q [$];
    logic [31:0] pat_mul  = 32'd3;
    logic [31:0] pat_add  = 32'd0;
    logic        rnd_mode = 1'b0;
    int          rnd_phase = 0;
    logic        bub_en   = 1'b0;
    logic        seen_first = 1'b0;
    int          bubbles  = 0;
    int          outst    = 0;
    int          grants   = 0;
    int          full_seen = 0;
    logic        p_valid, p_ready, p_rst;
    logic [31:0] p_data;
    logic [7:0]  p_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            out_ready_i = (rnd_phase == 0);
            rnd_phase   = (rnd_phase + 1) % 3;
            rd_gnt_i    = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(i), 32'(i) * pat_mul + pat_add});
        end
    endtask

    task automatic done_store();
        dm_we_i = 4'b0001; dm_addr_i = 16'hFFFC; dm_wdata_i = 32'h0000_00FF;
        tick();
        dm_we_i = 4'b0000; dm_wdata_i = 32'h0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 2000 && !drain_done_o; k++) tick();
        check({name, "_drain_done"}, 32'(drain_done_o), 32'd1);
        tick();
        check({name, "_busy_end"}, 32'(busy_o), 32'd0);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // DM model: one-cycle read latency, data derived from the word offset.
    always @(posedge clk) begin
        if (rd_req_o && rd_gnt_i)
            rd_data_i <= 32'((rd_addr_o - 16'h9000) >> 2) * pat_mul + pat_add;
        else
            rd_data_i <= 32'hDEAD_0000;
    end

    // Words granted but not yet accepted, plus read address check on each grant.
    always @(posedge clk) begin
        if (!rst) begin
            outst  = 0;
            grants = 0;
        end else begin
            if (rd_req_o && rd_gnt_i) begin
                check("rd_addr", 32'(rd_addr_o), 32'(16'h9000 + 16'(grants * 4)));
                grants++;
                outst++;
            end
            if (out_valid_o && out_ready_i) outst--;
        end
    end

    always @(negedge clk) begin
        logic [39:0] e;
        if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(out_idx_o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_idx", 32'(out_idx_o), 32'(e[39:32]));
                check("out_data", out_data_o, e[31:0]);
                check("out_last", 32'(out_last_o), 32'(e[39:32] == 8'd63));
            end
            seen_first = 1'b1;
        end
        if (bub_en && seen_first && !drain_done_o && !out_valid_o) bubbles++;
        if (rst && p_rst && p_valid && !p_ready) begin
            check("stall_valid", 32'(out_valid_o), 32'd1);
            check("stall_data", out_data_o, p_data);
            check("stall_idx", 32'(out_idx_o), 32'(p_idx));
        end
        if (rst && busy_o && outst >= 2 && !(out_valid_o && out_ready_i)) begin
            full_seen++;
            check("req_drop_full", 32'(rd_req_o), 32'd0);
        end
        p_valid = out_valid_o;
        p_ready = out_ready_i;
        p_rst   = rst;
        p_data  = out_data_o;
        p_idx   = out_idx_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; dm_we_i = 4'h0; dm_addr_i = 16'h0; dm_wdata_i = 32'h0;
        rd_gnt_i = 1'b0; out_ready_i = 1'b0;
        p_valid = 1'b0; p_ready = 1'b0; p_rst = 1'b0; p_data = 32'h0; p_idx = 8'h0;

        // T1: reset and idle counting
        repeat (10) tick();
        check("rst_rd_req", 32'(rd_req_o), 32'd0);
        check("rst_rd_addr", 32'(rd_addr_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", out_data_o, 32'd0);
        check("rst_idx", 32'(out_idx_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_done_seen", 32'(done_seen_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_drain_done", 32'(drain_done_o), 32'd0);
        check("rst_ovw", 32'(ovw_err_o), 32'd0);
        check("rst_cycle_cnt", cycle_cnt_o, 32'd0);
        rst = 1'b1;
        repeat (100) tick();
        check("idle_cycle_cnt", cycle_cnt_o, 32'd100);
        check("idle_rd_req", 32'(rd_req_o), 32'd0);

        // T2: near-miss stores, then the real done store
        dm_we_i = 4'b0001; dm_addr_i = 16'hFFFC; dm_wdata_i = 32'h0000_00FE;
        tick();
        dm_we_i = 4'b0010; dm_wdata_i = 32'h0000_00FF;
        tick();
        dm_we_i = 4'b0000;
        check("nodetect_fe_we2", 32'(done_seen_o), 32'd0);
        check("nodetect_cnt", cycle_cnt_o, 32'd102);

        // T3: full drain, grant always, ready always, answer[i] = i*3
        pat_mul = 32'd3; pat_add = 32'd0;
        rd_gnt_i = 1'b1; out_ready_i = 1'b1;
        push_expected(64);
        bub_en = 1'b1; seen_first = 1'b0; bubbles = 0;
        done_store();
        check("detect_done_seen", 32'(done_seen_o), 32'd1);
        check("detect_cnt_frozen", cycle_cnt_o, 32'd102);
        check("detect_busy", 32'(busy_o), 32'd1);
        wait_drain("t3");
        bub_en = 1'b0;
        check("t3_bubbles", 32'(bubbles), 32'd0);
        check("t3_cnt_held", cycle_cnt_o, 32'd102);

        // T4/T5: backpressure with random grants, overwrite detection
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pat_mul = 32'd7; pat_add = 32'h0000_1000;
        rnd_mode = 1'b1; rnd_phase = 0;
        push_expected(64);
        done_store();
        full_seen = 0;
        for (int k = 0; k < 2000 && !drain_done_o; k++) begin
            dm_we_i = 4'b0000;
            if (k == 20) begin
                check("t5_busy", 32'(busy_o), 32'd1);
                dm_we_i = 4'b1111; dm_addr_i = 16'h8FFC; dm_wdata_i = 32'hDEAD_BEEF;
            end
            if (k == 21) check("t5_ovw_below", 32'(ovw_err_o), 32'd0);
            if (k == 22) begin
                dm_we_i = 4'b0100; dm_addr_i = 16'h9010; dm_wdata_i = 32'h1234_5678;
            end
            if (k == 23) check("t5_ovw_inside", 32'(ovw_err_o), 32'd1);
            tick();
        end
        dm_we_i = 4'b0000;
        rnd_mode = 1'b0;
        wait_drain("t4");
        check("t4_full_exercised", 32'(full_seen > 0), 32'd1);

        // T6: reset mid-drain with a read in flight, then restart
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rd_gnt_i = 1'b1; out_ready_i = 1'b1;
        pat_mul = 32'd5; pat_add = 32'h0000_0100;
        push_expected(12);
        done_store();
        for (int k = 0; k < 500; k++) begin
            if (out_valid_o && out_ready_i && out_idx_o == 8'd10) break;
            tick();
        end
        check("t6_reached_w10", 32'(out_idx_o), 32'd10);
        tick();
        rst = 1'b0;
        tick();
        check("t6_rst_valid", 32'(out_valid_o), 32'd0);
        check("t6_rst_req", 32'(rd_req_o), 32'd0);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_done_seen", 32'(done_seen_o), 32'd0);
        check("t6_rst_cnt", cycle_cnt_o, 32'd0);
        check("t6_rst_data", out_data_o, 32'd0);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        tick();
        check("t6_late_data_dropped", 32'(out_valid_o), 32'd0);
        push_expected(64);
        done_store();
        wait_drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
